// File: rtl/vfp_config_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : vfp_config_axil_master
// Purpose  : AXI4-Lite initiator for the VFP video-configuration register
//            port. Turns a single-outstanding command/response interface
//            into AXI4-Lite write and read transactions. Reports the
//            response code and read data, and flags a slave that stalls.
// Ports    : vfpconfig_aclk / vfpconfig_aresetn - clock, async active-low reset
//            cmd_*      - command request (valid/ready, write, addr, data, strobes)
//            rsp_*      - one-cycle completion pulse with read data and resp code
//            timeout    - high while the current transaction has waited too long
//            vfpconfig_aw*/w*/b*/ar*/r* - AXI4-Lite master channels
// Revision : 1.0 - initial release
// ============================================================================
module vfp_config_axil_master #(
    parameter int C_vfpConfig_DATA_WIDTH = 32,
    parameter int C_vfpConfig_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES         = 1024
) (
    input  logic                                  vfpconfig_aclk,
    input  logic                                  vfpconfig_aresetn,
    // command / response interface
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_write,
    input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_vfpConfig_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                  rsp_valid,
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                            rsp_resp,
    output logic                                  timeout,
    // AXI4-Lite write address channel
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_awaddr,
    output logic [2:0]                            vfpconfig_awprot,
    output logic                                  vfpconfig_awvalid,
    input  logic                                  vfpconfig_awready,
    // AXI4-Lite write data channel
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_wdata,
    output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   vfpconfig_wstrb,
    output logic                                  vfpconfig_wvalid,
    input  logic                                  vfpconfig_wready,
    // AXI4-Lite write response channel
    input  logic [1:0]                            vfpconfig_bresp,
    input  logic                                  vfpconfig_bvalid,
    output logic                                  vfpconfig_bready,
    // AXI4-Lite read address channel
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_araddr,
    output logic [2:0]                            vfpconfig_arprot,
    output logic                                  vfpconfig_arvalid,
    input  logic                                  vfpconfig_arready,
    // AXI4-Lite read data channel
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_rdata,
    input  logic [1:0]                            vfpconfig_rresp,
    input  logic                                  vfpconfig_rvalid,
    output logic                                  vfpconfig_rready
);

    localparam int         c_DW = C_vfpConfig_DATA_WIDTH;
    localparam int         c_AW = C_vfpConfig_ADDR_WIDTH;
    localparam int         c_SW = C_vfpConfig_DATA_WIDTH / 8;
    localparam logic [15:0] c_TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] c_CNT_MAX       = 16'hFFFF;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_WADDR = 3'd1;
    localparam logic [2:0] c_S_WRESP = 3'd2;
    localparam logic [2:0] c_S_RADDR = 3'd3;
    localparam logic [2:0] c_S_RDATA = 3'd4;

    logic [2:0]      state_q,     state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            awvalid_q,   awvalid_d;
    logic            wvalid_q,    wvalid_d;
    logic            bready_q,    bready_d;
    logic            arvalid_q,   arvalid_d;
    logic            rready_q,    rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [c_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q,  rsp_resp_d;
    logic            timeout_q,   timeout_d;
    logic [15:0]     wait_cnt_q,  wait_cnt_d;
    logic [c_AW-1:0] addr_q,      addr_d;
    logic [c_DW-1:0] wdata_q,     wdata_d;
    logic [c_SW-1:0] wstrb_q,     wstrb_d;

    // Handshake terms
    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_accept  = (state_q == c_S_IDLE) && cmd_valid && cmd_ready_q;
    assign w_aw_hs   = awvalid_q && vfpconfig_awready;
    assign w_w_hs    = wvalid_q  && vfpconfig_wready;
    // A channel counts as done if it already handshook or handshakes now,
    // which lets AW and W complete in either order or together.
    assign w_aw_done = !awvalid_q || w_aw_hs;
    assign w_w_done  = !wvalid_q  || w_w_hs;
    assign w_b_hs    = (state_q == c_S_WRESP) && bready_q && vfpconfig_bvalid;
    assign w_ar_hs   = arvalid_q && vfpconfig_arready;
    assign w_r_hs    = (state_q == c_S_RDATA) && rready_q && vfpconfig_rvalid;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
        if (!vfpconfig_aresetn) begin
            state_q     <= c_S_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= 16'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: begin
                if (w_accept) begin
                    state_d = cmd_write ? c_S_WADDR : c_S_RADDR;
                end
            end
            c_S_WADDR: begin
                if (w_aw_done && w_w_done) begin
                    state_d = c_S_WRESP;
                end
            end
            c_S_WRESP: begin
                if (w_b_hs) begin
                    state_d = c_S_IDLE;
                end
            end
            c_S_RADDR: begin
                if (w_ar_hs) begin
                    state_d = c_S_RDATA;
                end
            end
            c_S_RDATA: begin
                if (w_r_hs) begin
                    state_d = c_S_IDLE;
                end
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (all outputs leave from registers)
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_d = (state_d == c_S_IDLE);
        bready_d    = (state_d == c_S_WRESP);
        arvalid_d   = (state_d == c_S_RADDR);
        rready_d    = (state_d == c_S_RDATA);

        // AW and W valids are tracked separately because their
        // handshakes are independent.
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        if (w_accept && cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else begin
            if (w_aw_hs) begin
                awvalid_d = 1'b0;
            end
            if (w_w_hs) begin
                wvalid_d = 1'b0;
            end
        end

        rsp_valid_d = w_b_hs || w_r_hs;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        if (w_b_hs) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = vfpconfig_bresp;
        end else if (w_r_hs) begin
            rsp_rdata_d = vfpconfig_rdata;
            rsp_resp_d  = vfpconfig_rresp;
        end

        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wait_cnt_d = wait_cnt_q;
        if (w_accept) begin
            addr_d     = cmd_addr;
            wdata_d    = cmd_wdata;
            wstrb_d    = cmd_wstrb;
            wait_cnt_d = 16'd0;
        end else if ((state_q != c_S_IDLE) && (wait_cnt_q != c_CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end

        // Gated by the next state so the flag drops together with the
        // completion pulse when the FSM returns to IDLE.
        timeout_d = (state_d != c_S_IDLE) && (wait_cnt_d >= c_TIMEOUT_LIMIT);
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_resp          = rsp_resp_q;
    assign timeout           = timeout_q;
    assign vfpconfig_awaddr  = addr_q;
    assign vfpconfig_awprot  = 3'b000;
    assign vfpconfig_awvalid = awvalid_q;
    assign vfpconfig_wdata   = wdata_q;
    assign vfpconfig_wstrb   = wstrb_q;
    assign vfpconfig_wvalid  = wvalid_q;
    assign vfpconfig_bready  = bready_q;
    assign vfpconfig_araddr  = addr_q;
    assign vfpconfig_arprot  = 3'b000;
    assign vfpconfig_arvalid = arvalid_q;
    assign vfpconfig_rready  = rready_q;

endmodule
`default_nettype wire

// File: doc/vfp_config_axil_master.md
Name: vfp_config_axil_master

Overview:
- AXI4-Lite initiator that drives the VFP video-configuration register port (vfpconfig_* slave) from a simple single-outstanding command interface.
- Used by the testbench config agent and by on-chip boot sequencers to program filter selects and thresholds, and to read back status registers.
- Exactly one transaction is in flight at a time.
- Reports the AXI response code and read data, and flags hung slaves.

Parameters:
- C_vfpConfig_DATA_WIDTH, 32: AXI data width; must be 32.
- C_vfpConfig_ADDR_WIDTH, 8: AXI byte-address width.
- TIMEOUT_CYCLES, 1024: wait-cycle count before timeout asserts; range 2..65535.

Ports:
- vfpconfig_aclk  in  1  sole clock.
- vfpconfig_aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured.
- timeout  out  1  sticky while the current transaction exceeds TIMEOUT_CYCLES.
- vfpconfig_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1.
- vfpconfig_awready  in  1.
- vfpconfig_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1.
- vfpconfig_wready  in  1.
- vfpconfig_bresp/bvalid  in  2/1.
- vfpconfig_bready  out  1.
- vfpconfig_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1.
- vfpconfig_arready  in  1.
- vfpconfig_rdata/rresp/rvalid  in  DATA_WIDTH/2/1.
- vfpconfig_rready  out  1.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE. Reset mid-transaction drops all valid and ready outputs asynchronously with no response.
- All outputs are registered. awprot and arprot are fixed at 3'b000.
- IDLE: a cmd_valid&cmd_ready handshake latches addr, wdata, wstrb and write, and clears the wait counter.
  - Write goes to WADDR. Next cycle awvalid=wvalid=1.
  - Read goes to RADDR. Next cycle arvalid=1.
  - cmd_ready drops the cycle after acceptance.
- WADDR:
  - awvalid clears the cycle after awvalid&awready; wvalid clears the cycle after wvalid&wready.
  - The two handshakes may occur in either order or in the same cycle.
  - Once both have completed, go to WRESP with bready=1.
  - Valids never drop before their handshake, and address/data stay stable while valid.
- WRESP: on bvalid&bready, capture bresp, drop bready, pulse rsp_valid with rsp_rdata=0, and return to IDLE. cmd_ready=1 in the same cycle as rsp_valid.
- RADDR: on arvalid&arready, drop arvalid and go to RDATA with rready=1.
- RDATA: on rvalid&rready, capture rdata and rresp, drop rready, pulse rsp_valid, and return to IDLE.
- Minimum latency (slave always ready, single-cycle response):
  - Write: acceptance at cycle 0, rsp_valid at cycle 4.
  - Read: acceptance at cycle 0, rsp_valid at cycle 4.
- rsp_rdata and rsp_resp hold their values until the next completion.
- Timeout:
  - A 16-bit wait counter increments every cycle outside IDLE and saturates.
  - timeout is set when the counter reaches TIMEOUT_CYCLES and clears on return to IDLE or on reset.
  - The transaction is never aborted (AXI protocol compliance); the FSM keeps waiting.
- cmd_valid while not in IDLE is ignored. Commands are neither queued nor lost, because cmd_ready=0.
- SLVERR/DECERR responses are passed through unchanged; the FSM still returns to IDLE.

Test Plan:
- Write addr 0x04, data 0x0000_00A5, wstrb 0xF, slave always ready: awvalid and wvalid rise together at cycle 1, rsp_valid at cycle 4, rsp_resp=0, rsp_rdata=0.
- Write with awready at cycle 2 and wready at cycle 6: awvalid low from cycle 3, wvalid held until cycle 6, bready rises at cycle 7, exactly one rsp_valid.
- Read addr 0x10, slave returns 0xDEAD_BEEF after a 3-cycle rvalid delay: rsp_rdata=0xDEADBEEF, rsp_resp=0, araddr stable while arvalid.
- Read with rresp=2'b10: rsp_resp=2'b10, FSM back in IDLE, cmd_ready=1 in the rsp_valid cycle.
- TIMEOUT_CYCLES=8, bvalid withheld for 20 cycles: timeout=1 from wait-cycle 8, bready held; at bvalid, rsp_valid pulses and timeout clears the next cycle.
- Assert vfpconfig_aresetn=0 while awvalid=1: awvalid, wvalid and rsp_valid go to 0 immediately. After release cmd_ready=1, and a new read completes normally.
